// File: rtl/seq_datapath_pkg.sv
// Shared op encodings, FSM states and small helpers for the sequential datapath.
package seq_datapath_pkg;

    localparam int unsigned AluOpW = 4;
    localparam int unsigned ShOpW  = 3;

    typedef enum logic [AluOpW-1:0] {
        AluPass   = 4'b0000,
        AluInc    = 4'b0001,
        AluAdd    = 4'b0010,
        AluAddInc = 4'b0011,
        AluAddNot = 4'b0100,
        AluSub    = 4'b0101,
        AluDec    = 4'b0110,
        AluPass7  = 4'b0111,
        AluAnd    = 4'b1000,
        AluOr     = 4'b1010,
        AluXor    = 4'b1100,
        AluNot    = 4'b1110
    } alu_op_e;

    typedef enum logic [ShOpW-1:0] {
        ShNone  = 3'b000,
        ShShl   = 3'b001,
        ShShr   = 3'b010,
        ShClr   = 3'b011,
        ShNone4 = 3'b100,
        ShRol   = 3'b101,
        ShRor   = 3'b110,
        ShNone7 = 3'b111
    } shift_op_e;

    typedef enum logic [1:0] {StIdle, StExec, StShift, StWb} state_e;

    // Only these shift ops consume cycles; the rest (including clear) finish in EXEC.
    function automatic logic shift_active(logic [ShOpW-1:0] h);
        logic act;
        case (h)
            ShShl, ShShr, ShRol, ShRor: act = 1'b1;
            default:                    act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/alu_w.sv
// Combinational W-bit ALU: adder-based ops report carry and signed overflow, logic ops do not.
module alu_w
    import seq_datapath_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]      a_i,
    input  logic [W-1:0]      b_i,
    input  logic [AluOpW-1:0] f_i,
    output logic [W-1:0]      result_o,
    output logic              v_o,
    output logic              c_o
);

    logic [W-1:0] b_eff;
    logic         cin;
    logic         use_adder;
    logic [W:0]   sum;

    always_comb begin
        b_eff     = '0;
        cin       = 1'b0;
        use_adder = 1'b1;
        result_o  = a_i;
        v_o       = 1'b0;
        c_o       = 1'b0;
        case (f_i)
            AluInc:    b_eff = W'(1);
            AluAdd:    b_eff = b_i;
            AluAddInc: begin b_eff = b_i;  cin = 1'b1; end
            AluAddNot: b_eff = ~b_i;
            AluSub:    begin b_eff = ~b_i; cin = 1'b1; end
            AluDec:    b_eff = '1;
            AluAnd:    begin use_adder = 1'b0; result_o = a_i & b_i; end
            AluOr:     begin use_adder = 1'b0; result_o = a_i | b_i; end
            AluXor:    begin use_adder = 1'b0; result_o = a_i ^ b_i; end
            AluNot:    begin use_adder = 1'b0; result_o = ~a_i; end
            default:   use_adder = 1'b0;
        endcase
        sum = {1'b0, a_i} + {1'b0, b_eff} + (W+1)'(cin);
        if (use_adder) begin
            result_o = sum[W-1:0];
            c_o      = sum[W];
            v_o      = (a_i[W-1] == b_eff[W-1]) && (sum[W-1] != a_i[W-1]);
        end
    end

endmodule

// File: rtl/seq_datapath.sv
// Multi-cycle datapath: register bank read, ALU, serial shift/rotate, write-back with
// a one-cycle response pulse.
module seq_datapath
    import seq_datapath_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = $clog2(NREG),
    parameter int unsigned SHW  = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [AW-1:0]  cmd_a,
    input  logic [AW-1:0]  cmd_b,
    input  logic [AW-1:0]  cmd_d,
    input  logic [3:0]     cmd_f,
    input  logic [2:0]     cmd_h,
    input  logic [SHW-1:0] cmd_shamt,
    input  logic           cmd_imm_sel,
    input  logic [W-1:0]   in_data,
    input  logic           il,
    input  logic           ir,
    output logic           rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           z,
    output logic           s,
    output logic           v,
    output logic           c,
    output logic           busy
);

    state_e         state_q;
    logic [W-1:0]   bank_q [NREG];
    logic [W-1:0]   op_a_q, op_b_q, acc_q;
    logic [AW-1:0]  d_q;
    logic [3:0]     f_q;
    logic [2:0]     h_q;
    logic [SHW-1:0] shamt_q, cnt_q;
    logic           v_ex_q, c_ex_q;
    logic           rsp_valid_q, z_q, s_q, v_q, c_q;
    logic [W-1:0]   rsp_data_q;

    logic [W-1:0]   alu_res, exec_val, shift_val, rsp_data_d;
    logic           alu_v, alu_c, k_zero, rsp_fire, rsp_v_d, rsp_c_d;

    alu_w #(
        .W (W)
    ) u_alu (
        .a_i      (op_a_q),
        .b_i      (op_b_q),
        .f_i      (f_q),
        .result_o (alu_res),
        .v_o      (alu_v),
        .c_o      (alu_c)
    );

    always_comb begin
        exec_val  = (h_q == ShClr) ? '0 : alu_res;
        k_zero    = !shift_active(h_q) || (shamt_q == '0);
        shift_val = acc_q;
        case (h_q)
            ShShl:   shift_val = {acc_q[W-2:0], ir};
            ShShr:   shift_val = {il, acc_q[W-1:1]};
            ShRol:   shift_val = {acc_q[W-2:0], acc_q[W-1]};
            ShRor:   shift_val = {acc_q[0], acc_q[W-1:1]};
            default: shift_val = acc_q;
        endcase
        // The response is captured on the edge entering WB, so it sees the final acc value.
        rsp_fire = ((state_q == StExec) && k_zero) ||
                   ((state_q == StShift) && (cnt_q == SHW'(1)));
        if (state_q == StExec) begin
            rsp_data_d = exec_val;
            rsp_v_d    = alu_v;
            rsp_c_d    = alu_c;
        end else begin
            rsp_data_d = shift_val;
            rsp_v_d    = v_ex_q;
            rsp_c_d    = c_ex_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            for (int unsigned i = 0; i < NREG; i++) begin
                bank_q[i] <= '0;
            end
            op_a_q      <= '0;
            op_b_q      <= '0;
            acc_q       <= '0;
            d_q         <= '0;
            f_q         <= '0;
            h_q         <= '0;
            shamt_q     <= '0;
            cnt_q       <= '0;
            v_ex_q      <= 1'b0;
            c_ex_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            z_q         <= 1'b0;
            s_q         <= 1'b0;
            v_q         <= 1'b0;
            c_q         <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_a_q  <= cmd_imm_sel ? in_data : bank_q[cmd_a];
                        op_b_q  <= bank_q[cmd_b];
                        d_q     <= cmd_d;
                        f_q     <= cmd_f;
                        h_q     <= cmd_h;
                        shamt_q <= cmd_shamt;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    acc_q   <= exec_val;
                    v_ex_q  <= alu_v;
                    c_ex_q  <= alu_c;
                    cnt_q   <= shamt_q;
                    state_q <= k_zero ? StWb : StShift;
                end
                StShift: begin
                    acc_q <= shift_val;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_q <= StWb;
                    end
                end
                StWb: begin
                    bank_q[d_q] <= acc_q;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            if (rsp_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rsp_data_d;
                z_q         <= (rsp_data_d == '0);
                s_q         <= rsp_data_d[W-1];
                v_q         <= rsp_v_d;
                c_q         <= rsp_c_d;
            end
        end
    end

    assign cmd_ready = reset_n && (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign z         = z_q;
    assign s         = s_q;
    assign v         = v_q;
    assign c         = c_q;

endmodule
